// File: rtl/tetris_pkg.sv
// Shared types for the playfield engines: piece codes, clear-engine FSM states
// and a sizing helper for row indices.
package tetris_pkg;

   typedef enum logic [1:0] {
      PIECE_SINGLE = 2'b00,
      PIECE_DOMINO = 2'b01,
      PIECE_SQUARE = 2'b10,
      PIECE_L      = 2'b11
   } piece_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SCAN,
      ST_FILL,
      ST_SPAWN,
      ST_DONE
   } state_e;

   // Bits needed to index ROWS rows (ROW_W in the engine).
   function automatic int row_bits(input int rows);
      return (rows > 1) ? $clog2(rows) : 1;
   endfunction

endpackage

// File: rtl/line_clear_engine_spawn_mask.sv
// Combinational piece-to-board mask for the 2x2 spawn window; also used by the
// move/rotate collision checker.
module spawn_mask
   import tetris_pkg::*;
#(
   parameter int ROWS      = 8,
   parameter int COLS      = 4,
   parameter int SPAWN_COL = 1
) (
   input  logic [1:0]           curr_piece,
   output logic [ROWS*COLS-1:0] mask
);

   localparam int C0 = SPAWN_COL;
   localparam int C1 = SPAWN_COL + 1;
   localparam int R1 = COLS;

   always_comb begin
      mask     = '0;
      mask[C0] = 1'b1;
      case (piece_e'(curr_piece))
         PIECE_DOMINO: mask[C1] = 1'b1;
         PIECE_SQUARE: begin
            mask[C1]      = 1'b1;
            mask[R1 + C0] = 1'b1;
            mask[R1 + C1] = 1'b1;
         end
         PIECE_L: begin
            mask[R1 + C0] = 1'b1;
            mask[R1 + C1] = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/line_clear_engine.sv
// Line-clear and spawn engine: scans a latched board bottom-up one row per
// cycle, compacts non-full rows downward, zero-fills the top, then spawns.
module line_clear_engine
   import tetris_pkg::*;
#(
   parameter int ROWS      = 8,
   parameter int COLS      = 4,
   parameter int SPAWN_COL = 1,
   parameter int SCORE_W   = 16
) (
   input  logic                      clka,
   input  logic                      restart_n,
   input  logic                      start,
   input  logic                      spawn_en,
   input  logic [1:0]                curr_piece,
   input  logic [ROWS*COLS-1:0]      board_in,
   output logic [ROWS*COLS-1:0]      board_out,
   output logic                      busy,
   output logic                      done,
   output logic [$clog2(ROWS+1)-1:0] lines_cleared,
   output logic [SCORE_W-1:0]        score,
   output logic                      game_over
);

   localparam int ROW_W = row_bits(ROWS);
   localparam int CNT_W = $clog2(ROWS + 1);

   state_e                    state;
   logic [ROWS-1:0][COLS-1:0] work;
   logic [ROW_W-1:0]          rd;
   logic [ROW_W:0]            wr;
   logic [CNT_W-1:0]          count;
   logic                      spawn_q;
   logic [1:0]                piece_q;
   logic [ROWS*COLS-1:0]      mask;
   logic [SCORE_W:0]          score_sum;

   spawn_mask #(.ROWS(ROWS), .COLS(COLS), .SPAWN_COL(SPAWN_COL)) u_mask (
      .curr_piece (piece_q),
      .mask       (mask)
   );

   assign score_sum = {1'b0, score} + (SCORE_W+1)'(count);

   always_ff @(posedge clka or negedge restart_n) begin
      if (!restart_n) begin
         state         <= ST_IDLE;
         work          <= '0;
         rd            <= '0;
         wr            <= '0;
         count         <= '0;
         spawn_q       <= 1'b0;
         piece_q       <= '0;
         board_out     <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         lines_cleared <= '0;
         score         <= '0;
         game_over     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               busy <= 1'b0;
               if (start && !game_over) begin
                  work    <= board_in;
                  spawn_q <= spawn_en;
                  piece_q <= curr_piece;
                  rd      <= ROW_W'(ROWS - 1);
                  wr      <= (ROW_W+1)'(ROWS - 1);
                  count   <= '0;
                  busy    <= 1'b1;
                  state   <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               // In-place compaction is safe: wr never drops below rd.
               if (&work[rd]) begin
                  count <= count + CNT_W'(1);
               end else begin
                  work[wr[ROW_W-1:0]] <= work[rd];
                  wr                  <= wr - (ROW_W+1)'(1);
               end
               rd <= rd - ROW_W'(1);
               if (rd == '0) state <= ST_FILL;
            end
            ST_FILL: begin
               // Surviving rows end at wr+1, so rows 0..wr are exactly the first count rows.
               for (int r = 0; r < ROWS; r++)
                  if (CNT_W'(r) < count) work[r] <= '0;
               state <= ST_SPAWN;
            end
            ST_SPAWN: begin
               if (spawn_q) begin
                  work <= work | mask;
                  if (|(work & mask)) game_over <= 1'b1;
               end
               state <= ST_DONE;
            end
            ST_DONE: begin
               done          <= 1'b1;
               board_out     <= work;
               lines_cleared <= count;
               score         <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
               state         <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
